// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Responder side of the MEM-stage load/store channel. The core issues one
// request at a time over a valid/ready handshake; this block waits a fixed
// number of cycles, performs a byte/half/word access on an internal 32-bit
// word array (little-endian) and returns a single response over a second
// valid/ready handshake. Misaligned accesses and the reserved size code are
// answered immediately with an error and never touch the array.
//
// Parameters
//   ADDR_W   word-address bits; the array holds 2**ADDR_W 32-bit words
//   LATENCY  cycles from the accept edge to the response (must be >= 1)
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   rst_i          synchronous reset, active high
//   req_valid_i    request present
//   req_ready_o    responder can take a request (only while idle)
//   req_we_i       1 = store, 0 = load
//   req_addr_i     byte address; bits above ADDR_W+1 are ignored (wrap)
//   req_wdata_i    store data, right-aligned
//   req_size_i     00 byte, 01 half, 10 word, 11 reserved (error)
//   req_signed_i   loads: 1 = sign-extend, 0 = zero-extend
//   rsp_valid_o    response present
//   rsp_ready_i    initiator consumes the response
//   rsp_rdata_o    extended load data; 0 for stores and errors
//   rsp_err_o      misaligned access or reserved size
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  // Wide enough to hold LATENCY-1; a 1-bit counter covers LATENCY of 1 and 2.
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // Access helpers
  // -------------------------------------------------------------------------

  // A half must sit on an even byte, a word on a multiple of four; size 11
  // is always rejected.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] lane);
    logic err;
    err = 1'b0;
    case (size)
      2'b00:   err = 1'b0;
      2'b01:   err = lane[0];
      2'b10:   err = (lane != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

  // Merge right-aligned store data into the addressed lane(s) of a word,
  // leaving every other byte untouched.
  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] w;
    w = old_word;
    case (size)
      2'b00: begin
        case (lane)
          2'b00:   w[7:0]   = wdata[7:0];
          2'b01:   w[15:8]  = wdata[7:0];
          2'b10:   w[23:16] = wdata[7:0];
          default: w[31:24] = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (lane[1]) begin
          w[31:16] = wdata[15:0];
        end else begin
          w[15:0] = wdata[15:0];
        end
      end
      2'b10:   w = wdata;
      default: w = old_word;
    endcase
    return w;
  endfunction

  // Pick the addressed lane(s) out of a word and extend to 32 bits.
  // Word loads ignore the signed flag.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    if (lane[1]) begin
      h = word[31:16];
    end else begin
      h = word[15:0];
    end
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      2'b10:   r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               we_q, we_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [1:0]         lane_q, lane_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [1:0]         size_q, size_d;
  logic               signed_q, signed_d;

  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic [31:0]        mem_q [DEPTH];
  logic [31:0]        mem_rd_s;
  logic               mem_we_s;
  logic [31:0]        mem_wdata_s;

  assign mem_rd_s    = mem_q[idx_q];

  assign req_ready_o = req_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

  // Next-state, request capture, array access strobe and response values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    idx_d       = idx_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    signed_d    = signed_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we_s    = 1'b0;
    mem_wdata_s = store_merge(mem_rd_s, wdata_q, size_q, lane_q);

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          we_d        = req_we_i;
          idx_d       = req_addr_i[ADDR_W+1:2];
          lane_d      = req_addr_i[1:0];
          wdata_d     = req_wdata_i;
          size_d      = req_size_i;
          signed_d    = req_signed_i;
          req_ready_d = 1'b0;
          if (access_err(req_size_i, req_addr_i[1:0])) begin
            // Bad requests skip the wait and never reach the array.
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0000_0000;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          // Final wait edge: the store lands here, before RESP, so a
          // following load to the same word sees the new data.
          mem_we_s    = we_q;
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          if (we_q) begin
            rsp_rdata_d = 32'h0000_0000;
          end else begin
            rsp_rdata_d = load_extract(mem_rd_s, size_q, lane_q, signed_q);
          end
        end
      end

      ST_RESP: begin
        // Return to IDLE only; the next accept happens on a later edge.
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cnt_d       = {CNT_W{1'b0}};
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0000_0000;
        rsp_err_d   = 1'b0;
      end
    endcase
  end

  // Control and response registers; reset wins over every transition.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      we_q        <= 1'b0;
      idx_q       <= {ADDR_W{1'b0}};
      lane_q      <= 2'b00;
      wdata_q     <= 32'h0000_0000;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      idx_q       <= idx_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Word array write port; contents survive reset, but a reset on the
  // store edge cancels the pending write.
  always_ff @(posedge clk_i) begin
    if (mem_we_s && !rst_i) begin
      mem_q[idx_q] <= mem_wdata_s;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid, req_we, req_signed, rsp_ready;
  logic [1:0]  req_ready, rsp_valid, rsp_err;
  logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0][1:0]  req_size;

  int tests_run = 0;
  int fails = 0;

  // Byte-addressed reference memory, one per instance (12 byte-address bits
  // = 2**10 words, so higher bits wrap).
  logic [7:0] mm [2][4096];
  int lat_of [2] = '{2, 1};

  data_mem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
    .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]), .req_size_i(req_size[0]),
    .req_signed_i(req_signed[0]), .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0]));

  data_mem_responder #(.ADDR_W(10), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
    .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]), .req_size_i(req_size[1]),
    .req_signed_i(req_signed[1]), .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic logic model_err(input logic [31:0] a, input logic [1:0] size);
    if (size == 2'b11) return 1'b1;
    return (a % nbytes(size)) != 0;
  endfunction

  function automatic void model_store(input int s, input logic [31:0] a,
                                      input logic [31:0] d, input logic [1:0] size);
    for (int i = 0; i < nbytes(size); i++)
      mm[s][(a + i) % 4096] = 8'((d >> (8 * i)) & 32'hFF);
  endfunction

  function automatic logic [31:0] model_load(input int s, input logic [31:0] a,
                                             input logic [1:0] size, input logic sgn);
    logic [31:0] v;
    int n;
    n = nbytes(size);
    v = 32'd0;
    for (int i = 0; i < n; i++)
      v = v | (32'(mm[s][(a + i) % 4096]) << (8 * i));
    if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  // Runs one transaction and reports what was observed. lat = edges after the
  // accept edge until rsp_valid is seen; hs_bad flags handshake misbehaviour.
  task automatic do_txn(input int s, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] size, input logic sgn,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output logic hs_bad);
    int n;
    rdata = 32'd0; err = 1'b0; lat = -1; hs_bad = 1'b0;
    @(negedge clk);
    req_valid[s] = 1'b1; req_we[s] = we; req_addr[s] = a;
    req_wdata[s] = d; req_size[s] = size; req_signed[s] = sgn;
    n = 0;
    while (!req_ready[s] && n < 50) begin @(negedge clk); n++; end
    if (!req_ready[s]) begin req_valid[s] = 1'b0; return; end
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    lat = 0;
    while (!rsp_valid[s] && lat < 50) begin
      if (req_ready[s]) hs_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    rdata = rsp_rdata[s]; err = rsp_err[s];
    if (req_ready[s]) hs_bad = 1'b1;
    @(negedge clk);
    rsp_ready[s] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[s] = 1'b0;
    if (rsp_valid[s] || !req_ready[s]) hs_bad = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      tests_run++;
      if ({req_ready[s], rsp_valid[s], rsp_err[s], rsp_rdata[s]} !== {3'b100, 32'd0}) begin
        fails++;
        $display("FAIL reset[%0d]: got rdy=%b vld=%b err=%b rdata=%h, want 1 0 0 0",
                 s, req_ready[s], rsp_valid[s], rsp_err[s], rsp_rdata[s]);
      end
    end
  endtask

  task automatic test_basic(input int s);
    logic [31:0] r; logic e; int l; logic hb;
    do_txn(s, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, r, e, l, hb);
    model_store(s, 32'h10, 32'hDEADBEEF, 2'b10);
    tests_run++;
    if ({r, e, hb} !== {32'd0, 2'b00} || l != lat_of[s]) begin
      fails++;
      $display("FAIL sw_basic[%0d]: got rdata=%h err=%b hs_bad=%b lat=%0d, want 0 0 0 lat=%0d",
               s, r, e, hb, l, lat_of[s]);
    end
    do_txn(s, 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, r, e, l, hb);
    tests_run++;
    if ({r, e, hb} !== {32'hDEADBEEF, 2'b00} || l != lat_of[s]) begin
      fails++;
      $display("FAIL lw_basic[%0d]: got rdata=%h err=%b hs_bad=%b lat=%0d, want deadbeef 0 0 lat=%0d",
               s, r, e, hb, l, lat_of[s]);
    end
  endtask

  task automatic test_subword();
    logic [31:0] r; logic e; int l; logic hb;
    logic [31:0] want [4] = '{32'hFFFFFF80, 32'h00000080, 32'h80ADBEEF, 32'h000080AD};
    logic [31:0] addr [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
    logic [1:0]  sz   [4] = '{2'b00, 2'b00, 2'b10, 2'b01};
    logic        sg   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    do_txn(0, 1'b1, 32'h13, 32'h00000080, 2'b00, 1'b0, r, e, l, hb);
    model_store(0, 32'h13, 32'h80, 2'b00);
    tests_run++;
    if ({r, e} !== {32'd0, 1'b0}) begin
      fails++;
      $display("FAIL sb: got rdata=%h err=%b, want 0 0", r, e);
    end
    for (int i = 0; i < 4; i++) begin
      do_txn(0, 1'b0, addr[i], 32'd0, sz[i], sg[i], r, e, l, hb);
      tests_run++;
      if (r !== want[i] || e !== 1'b0 || r !== model_load(0, addr[i], sz[i], sg[i])) begin
        fails++;
        $display("FAIL subword_load%0d: got rdata=%h err=%b, want %h 0", i, r, e, want[i]);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] r; logic e; int l; logic hb;
    do_txn(0, 1'b0, 32'h12, 32'd0, 2'b10, 1'b0, r, e, l, hb);
    tests_run++;
    if ({r, e, hb} !== {32'd0, 2'b10} || l != 0) begin
      fails++;
      $display("FAIL misaligned_lw: got rdata=%h err=%b hs_bad=%b lat=%0d, want 0 1 0 lat=0", r, e, hb, l);
    end
    do_txn(0, 1'b1, 32'h11, 32'h5555, 2'b01, 1'b0, r, e, l, hb);
    tests_run++;
    if ({r, e} !== {32'd0, 1'b1} || l != 0) begin
      fails++;
      $display("FAIL misaligned_sh: got rdata=%h err=%b lat=%0d, want 0 1 lat=0", r, e, l);
    end
    do_txn(0, 1'b0, 32'h10, 32'd0, 2'b11, 1'b0, r, e, l, hb);
    tests_run++;
    if ({r, e} !== {32'd0, 1'b1}) begin
      fails++;
      $display("FAIL size11: got rdata=%h err=%b, want 0 1", r, e);
    end
    do_txn(0, 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, r, e, l, hb);
    tests_run++;
    if ({r, e} !== {32'h80ADBEEF, 1'b0}) begin
      fails++;
      $display("FAIL after_err_lw: got rdata=%h err=%b, want 80adbeef 0", r, e);
    end
  endtask

  task automatic test_stall();
    logic [31:0] r0; logic e0; int n; logic bad;
    logic [31:0] r; logic e; int l; logic hb;
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 32'h10;
    req_size[0] = 2'b10; req_signed[0] = 1'b0;
    @(posedge clk); #1;
    // Intruder store presented while busy; it must never be taken.
    req_we[0] = 1'b1; req_wdata[0] = 32'h0BADF00D;
    n = 0;
    while (!rsp_valid[0] && n < 20) begin @(posedge clk); #1; n++; end
    r0 = rsp_rdata[0]; e0 = rsp_err[0];
    tests_run++;
    if ({r0, e0} !== {32'h80ADBEEF, 1'b0}) begin
      fails++;
      $display("FAIL stall_first: got rdata=%h err=%b, want 80adbeef 0", r0, e0);
    end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid[0] || req_ready[0] || rsp_rdata[0] !== r0 || rsp_err[0] !== e0) bad = 1'b1;
    end
    tests_run++;
    if (bad !== 1'b0) begin
      fails++;
      $display("FAIL stall_hold: got unstable=%b, want 0", bad);
    end
    @(negedge clk);
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    tests_run++;
    if ({rsp_valid[0], req_ready[0]} !== 2'b01) begin
      fails++;
      $display("FAIL stall_release: got vld=%b rdy=%b, want 0 1", rsp_valid[0], req_ready[0]);
    end
    req_valid[0] = 1'b0;
    do_txn(0, 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, r, e, l, hb);
    tests_run++;
    if (r !== 32'h80ADBEEF || hb !== 1'b0) begin
      fails++;
      $display("FAIL stall_no_accept: got rdata=%h hs_bad=%b, want 80adbeef 0", r, hb);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] r; logic e; int l; logic hb;
    do_txn(0, 1'b1, 32'h20, 32'h11112222, 2'b10, 1'b0, r, e, l, hb);
    model_store(0, 32'h20, 32'h11112222, 2'b10);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h20;
    req_wdata[0] = 32'h12345678; req_size[0] = 2'b10;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    // Reset lands on the edge that would have written the array.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if ({req_ready[0], rsp_valid[0]} !== 2'b10) begin
      fails++;
      $display("FAIL rst_wait_state: got rdy=%b vld=%b, want 1 0", req_ready[0], rsp_valid[0]);
    end
    do_txn(0, 1'b0, 32'h20, 32'd0, 2'b10, 1'b0, r, e, l, hb);
    tests_run++;
    if (r !== 32'h11112222) begin
      fails++;
      $display("FAIL rst_wait_nowrite: got rdata=%h, want 11112222", r);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] r; logic e; int l; logic hb;
    do_txn(0, 1'b1, 32'h1000, 32'hCAFEF00D, 2'b10, 1'b0, r, e, l, hb);
    model_store(0, 32'h1000, 32'hCAFEF00D, 2'b10);
    do_txn(0, 1'b0, 32'h0, 32'd0, 2'b10, 1'b0, r, e, l, hb);
    tests_run++;
    if (r !== 32'hCAFEF00D || e !== 1'b0) begin
      fails++;
      $display("FAIL wrap: got rdata=%h err=%b, want cafef00d 0", r, e);
    end
  endtask

  task automatic test_random(input int s, input int count);
    logic [31:0] r; logic e; int l; logic hb;
    logic [31:0] a, d, exp_r; logic [1:0] sz; logic we, sg, exp_e;
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      do_txn(s, 1'b1, 32'h100 + 32'(4 * w), d, 2'b10, 1'b0, r, e, l, hb);
      model_store(s, 32'h100 + 32'(4 * w), d, 2'b10);
    end
    for (int i = 0; i < count; i++) begin
      we = 1'($urandom_range(0, 1)); sg = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a = 32'h100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a = a + 32'h1000;
      d = $urandom;
      exp_e = model_err(a, sz);
      exp_r = (exp_e || we) ? 32'd0 : model_load(s, a, sz, sg);
      do_txn(s, we, a, d, sz, sg, r, e, l, hb);
      if (!exp_e && we) model_store(s, a, d, sz);
      tests_run++;
      if (r !== exp_r || e !== exp_e || hb !== 1'b0 || l != (exp_e ? 0 : lat_of[s])) begin
        fails++;
        $display("FAIL random[%0d.%0d] we=%b a=%h sz=%0d sg=%b: got rdata=%h err=%b hs_bad=%b lat=%0d, want %h %b 0 lat=%0d",
                 s, i, we, a, sz, sg, r, e, hb, l, exp_r, exp_e, exp_e ? 0 : lat_of[s]);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0; req_we = '0; req_signed = '0; rsp_ready = '0;
    req_addr = '0; req_wdata = '0; req_size = '0;
    test_reset();
    test_basic(0);
    test_subword();
    test_errors();
    test_stall();
    test_reset_mid_wait();
    test_wrap();
    test_basic(1);
    test_random(0, 80);
    test_random(1, 40);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
